// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern detector family.
package seq_pkg;

    typedef enum logic {
        FILL,
        ARMED
    } seq_state_e;

    localparam logic [3:0] PAT_1001 = 4'b1001;

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating match counter; a clear coinciding with an increment counts that match.
module seq_match_cnt #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          res,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          sat
);

    logic [CW-1:0] r_cnt;
    logic          r_sat;
    logic [CW-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt;
        if (clr) begin
            w_cnt_d = inc ? CW'(1) : '0;
        end else if (inc && !r_sat) begin
            w_cnt_d = r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else begin
            r_cnt <= w_cnt_d;
            r_sat <= &w_cnt_d;
        end
    end

    assign cnt = r_cnt;
    assign sat = r_sat;

endmodule

// File: rtl/seq_det_param.sv
// Parametrised serial pattern detector with loadable pattern, overlap select,
// valid-qualified input and a saturating match counter.
module seq_det_param
    import seq_pkg::*;
#(
    parameter int unsigned    W         = 4,
    parameter logic [W-1:0]   RESET_PAT = PAT_1001,
    parameter int unsigned    CW        = 8
) (
    input  logic          clk,
    input  logic          res,
    input  logic          x,
    input  logic          x_valid,
    input  logic [W-1:0]  pat,
    input  logic          pat_load,
    input  logic          ovl,
    input  logic          cnt_clr,
    output logic          out,
    output logic [CW-1:0] match_cnt,
    output logic          cnt_sat
);

    localparam int unsigned    FW        = $clog2(W + 1);
    localparam logic [FW-1:0]  FILL_FULL = FW'(W);
    localparam logic [FW-1:0]  FILL_LAST = FW'(W - 1);

    logic [W-1:0]  r_pat;
    // Only the W-1 most recent bits are kept; the incoming x completes the window.
    logic [W-2:0]  r_hist;
    logic [FW-1:0] r_fill;
    seq_state_e    r_state;
    logic          r_out;

    logic [W-1:0]  w_win;
    logic [FW-1:0] w_fill_d;
    seq_state_e    w_state_d;
    logic          w_accept;
    logic          w_ready;
    logic          w_match;

    assign w_accept = x_valid & ~pat_load;
    assign w_win    = {r_hist, x};
    assign w_ready  = (r_state == ARMED) || (r_fill == FILL_LAST);
    assign w_match  = w_accept && w_ready && (w_win == r_pat);

    always_comb begin
        w_fill_d  = r_fill;
        w_state_d = r_state;
        if (pat_load) begin
            w_fill_d  = '0;
            w_state_d = FILL;
        end else if (w_accept) begin
            if (w_match && !ovl) begin
                w_fill_d  = '0;
                w_state_d = FILL;
            end else if (r_state == ARMED) begin
                w_fill_d  = FILL_FULL;
                w_state_d = ARMED;
            end else begin
                w_fill_d  = r_fill + FW'(1);
                w_state_d = (r_fill == FILL_LAST) ? ARMED : FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            r_pat   <= RESET_PAT;
            r_hist  <= '0;
            r_fill  <= '0;
            r_state <= FILL;
            r_out   <= 1'b0;
        end else begin
            if (pat_load) begin
                r_pat <= pat;
            end
            if (w_accept) begin
                r_hist <= w_win[W-2:0];
            end
            r_fill  <= w_fill_d;
            r_state <= w_state_d;
            r_out   <= w_match;
        end
    end

    assign out = r_out;

    seq_match_cnt #(
        .CW(CW)
    ) u_cnt (
        .clk(clk),
        .res(res),
        .inc(w_match),
        .clr(cnt_clr),
        .cnt(match_cnt),
        .sat(cnt_sat)
    );

endmodule

// File: tb/tb_seq_det_param.sv
// Self-checking bench: default-width detector and a CW=2 twin share stimulus,
// both checked against a queue-based reference model.
module tb_seq_det_param;

    logic       clk;
    logic       res;
    logic       x;
    logic       x_valid;
    logic [3:0] pat;
    logic       pat_load;
    logic       ovl;
    logic       cnt_clr;

    logic       out;
    logic [7:0] match_cnt;
    logic       cnt_sat;
    logic       out_s;
    logic [1:0] match_cnt_s;
    logic       cnt_sat_s;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit         mq[$];
    logic [3:0] m_pat;
    bit         m_out;
    int         m_cnt;
    int         m_cnt_s;

    seq_det_param dut (
        .clk(clk), .res(res), .x(x), .x_valid(x_valid), .pat(pat),
        .pat_load(pat_load), .ovl(ovl), .cnt_clr(cnt_clr),
        .out(out), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    seq_det_param #(
        .W(4), .RESET_PAT(4'b1001), .CW(2)
    ) dut_s (
        .clk(clk), .res(res), .x(x), .x_valid(x_valid), .pat(pat),
        .pat_load(pat_load), .ovl(ovl), .cnt_clr(cnt_clr),
        .out(out_s), .match_cnt(match_cnt_s), .cnt_sat(cnt_sat_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model, then sample 1 ns after the edge.
    task automatic step(input logic xv, input logic xb, input logic pl, input logic [3:0] p,
                        input logic ov, input logic cl, input logic rs);
        logic [3:0] win;
        bit         hit;
        x = xb; x_valid = xv; pat_load = pl; pat = p; ovl = ov; cnt_clr = cl; res = rs;
        hit = 1'b0;
        if (!rs) begin
            mq.delete();
            m_pat = 4'b1001; m_out = 1'b0; m_cnt = 0; m_cnt_s = 0;
        end else begin
            if (pl) begin
                m_pat = p;
                mq.delete();
            end else if (xv) begin
                mq.push_back(xb);
                if (mq.size() > 4) mq.delete(0);
                if (mq.size() == 4) begin
                    win = {mq[0], mq[1], mq[2], mq[3]};
                    hit = (win == m_pat);
                end
                if (hit && !ov) mq.delete();
            end
            m_out = hit;
            if (cl) begin
                m_cnt = hit ? 1 : 0;
                m_cnt_s = hit ? 1 : 0;
            end else if (hit) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt_s < 3) m_cnt_s++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out !== 1'b0 || match_cnt !== 8'd0 || cnt_sat !== 1'b0) begin
            errors++;
            $display("FAIL reset: out=%b cnt=%0d sat=%b, required 0 0 0", out, match_cnt, cnt_sat);
        end
        checks++;
        if (out_s !== 1'b0 || match_cnt_s !== 2'd0 || cnt_sat_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_s: out=%b cnt=%0d sat=%b, required 0 0 0",
                     out_s, match_cnt_s, cnt_sat_s);
        end
    endtask

    task automatic test_stream(input logic ov);
        logic [6:0] stream;
        logic       exp;
        stream = 7'b1001001;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, stream[6-i], 1'b0, 4'h0, ov, 1'b0, 1'b1);
            exp = (i == 3) || (ov && i == 6);
            checks++;
            if (out !== exp || m_out !== exp) begin
                errors++;
                $display("FAIL stream_ovl%0b bit%0d: out=%b model=%b, required %b",
                         ov, i, out, m_out, exp);
            end
        end
        checks++;
        if (match_cnt !== (ov ? 8'd2 : 8'd1)) begin
            errors++;
            $display("FAIL stream_cnt_ovl%0b: cnt=%0d, required %0d", ov, match_cnt, ov ? 2 : 1);
        end
    endtask

    task automatic test_gapped();
        logic [3:0] bits;
        int         pulses;
        bits = 4'b1001;
        pulses = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, bits[3-i], 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
            checks++;
            if (out !== (i == 3)) begin
                errors++;
                $display("FAIL gapped bit%0d: out=%b, required %b", i, out, (i == 3));
            end
            if (out === 1'b1) pulses++;
            for (int g = 0; g < 3; g++) begin
                step(1'b0, 1'($urandom), 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
                if (out === 1'b1) pulses++;
            end
        end
        checks++;
        if (pulses != 1 || match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL gapped_pulses: pulses=%0d cnt=%0d, required 1 1", pulses, match_cnt);
        end
    endtask

    task automatic test_load();
        logic [7:0] seq;
        logic       exp;
        seq = 8'b1110_1001;
        do_reset();
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b1);
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL load_edge: out=%b, required 0", out);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, seq[7-i], 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
            exp = (i == 3);
            checks++;
            if (out !== exp) begin
                errors++;
                $display("FAIL load_seq bit%0d: out=%b, required %b", i, out, exp);
            end
        end
        checks++;
        if (match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL load_cnt: cnt=%0d, required 1", match_cnt);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
            checks++;
            if (out_s !== (i >= 3)) begin
                errors++;
                $display("FAIL sat_pulse bit%0d: out=%b, required %b", i, out_s, (i >= 3));
            end
        end
        checks++;
        if (match_cnt_s !== 2'd3 || cnt_sat_s !== 1'b1) begin
            errors++;
            $display("FAIL sat_cw2: cnt=%0d sat=%b, required 3 1", match_cnt_s, cnt_sat_s);
        end
        checks++;
        if (match_cnt !== 8'd5 || cnt_sat !== 1'b0) begin
            errors++;
            $display("FAIL sat_cw8: cnt=%0d sat=%b, required 5 0", match_cnt, cnt_sat);
        end
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (match_cnt_s !== 2'd1 || cnt_sat_s !== 1'b0 || match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL clr_with_match: cnt_s=%0d sat_s=%b cnt=%0d, required 1 0 1",
                     match_cnt_s, cnt_sat_s, match_cnt);
        end
        step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (match_cnt_s !== 2'd0 || match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clr_alone: cnt_s=%0d cnt=%0d, required 0 0", match_cnt_s, match_cnt);
        end
    endtask

    task automatic test_midreset();
        logic [4:0] tail;
        logic       exp;
        tail = 5'b11001;
        do_reset();
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out !== 1'b0 || match_cnt !== 8'd0 || cnt_sat !== 1'b0) begin
            errors++;
            $display("FAIL midreset: out=%b cnt=%0d sat=%b, required 0 0 0",
                     out, match_cnt, cnt_sat);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, tail[4-i], 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
            exp = (i == 4);
            checks++;
            if (out !== exp) begin
                errors++;
                $display("FAIL midreset_tail bit%0d: out=%b, required %b", i, out, exp);
            end
        end
    endtask

    task automatic test_random();
        logic cur_ovl;
        cur_ovl = 1'b1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) cur_ovl = ~cur_ovl;
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 40) == 0),
                 4'($urandom), cur_ovl, 1'($urandom_range(0, 60) == 0),
                 1'($urandom_range(0, 200) != 0));
            checks++;
            if (out !== m_out || match_cnt !== 8'(m_cnt) || cnt_sat !== (m_cnt == 255)) begin
                errors++;
                $display("FAIL random cyc%0d: out=%b cnt=%0d sat=%b, required %b %0d %b",
                         i, out, match_cnt, cnt_sat, m_out, m_cnt, (m_cnt == 255));
            end
            checks++;
            if (out_s !== m_out || match_cnt_s !== 2'(m_cnt_s) || cnt_sat_s !== (m_cnt_s == 3)) begin
                errors++;
                $display("FAIL random_s cyc%0d: out=%b cnt=%0d sat=%b, required %b %0d %b",
                         i, out_s, match_cnt_s, cnt_sat_s, m_out, m_cnt_s, (m_cnt_s == 3));
            end
        end
    endtask

    initial begin
        res = 1'b0; x = 1'b0; x_valid = 1'b0; pat = 4'h0; pat_load = 1'b0;
        ovl = 1'b1; cnt_clr = 1'b0;
        test_reset();
        test_stream(1'b1);
        test_stream(1'b0);
        test_gapped();
        test_load();
        test_saturate();
        test_midreset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_det_param.md
# seq_det_param

Parametrised serial pattern detector: the next generation of the team's fixed "1001" Moore sequence detector. The target pattern is a runtime-loadable W-bit value with a reset default, overlapping or non-overlapping matching is selectable, and input bits are qualified by a valid strobe. A saturating match counter is included. The block sits on a serial bit stream as a framing/marker detector, and its pulse output feeds downstream control logic.

## Interface
Parameters:
- `W`, default 4: pattern length in bits, W ≥ 2.
- `RESET_PAT`, default 4'b1001: pattern loaded at reset. It is W bits wide.
- `CW`, default 8: match counter width.

Ports:
- `clk` in 1: single clock. Everything is sampled on the rising edge.
- `res` in 1: reset. Synchronous and active-low: the block resets when `res` == 0 at the rising edge of `clk`.
- `x` in 1: serial input bit.
- `x_valid` in 1: `x` is accepted on this edge only when this is high.
- `pat` in W: new pattern value. The first-received bit is compared against `pat[W-1]`.
- `pat_load` in 1: load `pat` into the pattern register.
- `ovl` in 1: 1 = overlapping matches, 0 = non-overlapping.
- `cnt_clr` in 1: clear the match counter.
- `out` out 1: registered match pulse.
- `match_cnt` out CW: saturating count of matches.
- `cnt_sat` out 1: high while `match_cnt` is all-ones.

## Operation
- Internal state:
  - `pat_q` (W bits).
  - `hist` (W bits): the last W accepted bits, newest bit in `hist[0]`.
  - `fill` (0..W): number of valid history bits.
  - Two-state FSM: FILL when `fill` < W, ARMED when `fill` == W.
- Reset values: `pat_q` = RESET_PAT, `hist` = 0, `fill` = 0, state FILL, `out` = 0, `match_cnt` = 0, `cnt_sat` = 0.
- Accept, when `x_valid` = 1 and `pat_load` = 0:
  - `hist` ← {`hist[W-2:0]`, `x`}.
  - `fill` ← min(`fill`+1, W).
- Match condition: accept this edge, AND `fill`+1 ≥ W, AND {`hist[W-2:0]`, `x`} == `pat_q`.
- On a match:
  - If `ovl` = 1: `fill` stays W and the state stays ARMED.
  - If `ovl` = 0: `fill` ← 0 and the state goes to FILL. No bit of the matched window can contribute to a later match.
- `out` ← match. It is high for exactly one cycle per match, regardless of `x_valid` in the following cycle.
- FSM transitions:
  - FILL → ARMED when `fill` reaches W without a non-overlap match.
  - ARMED → FILL on a non-overlap match or on `pat_load`.
- `pat_load` = 1:
  - `pat_q` ← `pat`, `fill` ← 0, state FILL, `out` ← 0.
  - Any `x` presented in the same cycle is dropped, even if `x_valid` = 1.
- `ovl` is sampled on the accepting edge. Changing it never alters `hist`.
- Counter:
  - On a match, `match_cnt` ← `match_cnt`+1 unless it is all-ones. It saturates and does not wrap.
  - `cnt_sat` = (`match_cnt` == all-ones), registered together with the count.
  - If `cnt_clr` and a match occur on the same edge, `match_cnt` ← 1.
  - If `cnt_clr` occurs alone, `match_cnt` ← 0.
- Reset during operation discards partial history. The first match after reset needs W fresh accepted bits.

## Timing
- Latency: `out` rises on the edge after the edge that accepts the final pattern bit. This is the same Moore-style single-cycle delay as the current fixed detector.
- `match_cnt` updates on the same edge that `out` rises.
- Back-to-back matches in overlap mode can produce `out` high on consecutive cycles (for example, an all-ones pattern with a continuous input of 1s).
- `pat_load` takes effect immediately. A match that would have completed on the load edge is suppressed.
- Throughput: one bit per clock. There is no backpressure.

## Structure
- Shared package `seq_pkg`:
  - FSM state enum {FILL, ARMED}.
  - Default pattern constant PAT_1001 = 4'b1001.
  - Reuse this package for future detector variants.
- One sub-module, `seq_match_cnt`: a parametrised (CW) saturating counter with `inc`, `clr` and `sat`, implementing the clr+inc rule above.
- Top level: `hist`/`fill`/FSM logic, `pat_q` register, compare logic, and the registered `out`.

## Test plan
- Reset default, W=4, `ovl`=1, continuous `x_valid`:
  - Stream 1,0,0,1,0,0,1 → `out` pulses 1 cycle after the 4th bit and 1 cycle after the 7th bit.
  - `match_cnt` = 2.
- Same stream with `ovl`=0 → single pulse after the 4th bit, `match_cnt` = 1.
- Gapped valid: 1,0,0,1 with `x_valid` low for 3 cycles between each bit → exactly one pulse, one cycle after the last accepted bit. `x` toggling during the invalid cycles has no effect.
- Load `pat`=4'b1110 mid-stream, with `x_valid`=1 on the load cycle → that bit is dropped. Then:
  - 1,1,1,0 → pulse.
  - A subsequent 1,0,0,1 → no pulse.
- CW=2, all-ones pattern, 8 consecutive 1s with `ovl`=1:
  - `match_cnt` saturates at 3 and `cnt_sat`=1.
  - `cnt_clr` together with a match → `match_cnt`=1.
- Assert `res`=0 after 1,0,0 have been accepted → all outputs return to reset values. A following 1 alone gives no pulse. A full 1,0,0,1 then gives a pulse.
